// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words over a valid/ready port, shifts them out on sout
// with each bit held CLKS_PER_BIT clocks, and keeps one word buffered so back-to-back words have no gap.
module serial_bit_feeder #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             bit_en,
  output logic             busy,
  output logic             word_done
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  // Handshake: a word moves on a rising edge with din_valid && din_ready; din_ready depends only on
  // the holding buffer, so the source may keep din_valid high and din stable until it is taken.
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] buf_q, buf_nxt;
  logic             buf_full, buf_full_nxt;
  logic [DW-1:0]    div_cnt, div_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic             sout_nxt;
  logic             xfer, period_end, word_end, load;
  logic [WIDTH-1:0] load_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // The shift register holds only the bits still to be presented; sout carries the current one.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready  = !buf_full;
  assign xfer       = din_valid && din_ready;
  assign busy       = (state == SHIFT);
  assign period_end = busy && (div_cnt == DIV_LAST);
  assign word_end   = period_end && (bit_cnt == BIT_LAST);
  assign bit_en     = busy && (div_cnt == '0);
  assign word_done  = word_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sout     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      buf_q    <= buf_nxt;
      buf_full <= buf_full_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      sout     <= sout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    buf_nxt      = buf_q;
    buf_full_nxt = buf_full;
    div_nxt      = div_cnt;
    bit_nxt      = bit_cnt;
    sout_nxt     = sout;
    load         = 1'b0;
    load_word    = din;
    case (state)
      IDLE: begin
        if (xfer) load = 1'b1;
      end
      SHIFT: begin
        if (!period_end) begin
          div_nxt = div_cnt + DW'(1);
        end else if (!word_end) begin
          div_nxt   = '0;
          bit_nxt   = bit_cnt + BW'(1);
          sout_nxt  = first_bit(shreg);
          shreg_nxt = shift_out(shreg);
        end else if (buf_full) begin
          load         = 1'b1;
          load_word    = buf_q;
          buf_full_nxt = 1'b0;
        end else if (xfer) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
          sout_nxt  = 1'b0;
          div_nxt   = '0;
          bit_nxt   = '0;
        end
        // A word arriving on the last-bit edge bypasses the buffer (handled by the load above).
        if (xfer && !word_end) begin
          buf_nxt      = din;
          buf_full_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      state_nxt = SHIFT;
      sout_nxt  = first_bit(load_word);
      shreg_nxt = shift_out(load_word);
      div_nxt   = '0;
      bit_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: three instances (plain, 3 clocks/bit, LSB-first) checked
// every cycle against a model that expands each accepted word into the per-clock output it must produce.
module tb_serial_bit_feeder;

  localparam int CPB_T [3] = '{1, 3, 1};
  localparam int MSB_T [3] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_a [3];
  logic       din_valid_a [3];
  logic       din_ready_a [3];
  logic       sout_a [3];
  logic       bit_en_a [3];
  logic       busy_a [3];
  logic       word_done_a [3];

  // Expected {sout, bit_en, word_done} for each upcoming clock of the selected instance.
  logic [2:0] exp_q [$];
  int         sel;
  int         n_checks;
  int         n_fails;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .reset(reset), .din(din_a[0]), .din_valid(din_valid_a[0]),
    .din_ready(din_ready_a[0]), .sout(sout_a[0]), .bit_en(bit_en_a[0]),
    .busy(busy_a[0]), .word_done(word_done_a[0]));

  serial_bit_feeder #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .din(din_a[1]), .din_valid(din_valid_a[1]),
    .din_ready(din_ready_a[1]), .sout(sout_a[1]), .bit_en(bit_en_a[1]),
    .busy(busy_a[1]), .word_done(word_done_a[1]));

  serial_bit_feeder #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .reset(reset), .din(din_a[2]), .din_valid(din_valid_a[2]),
    .din_ready(din_ready_a[2]), .sout(sout_a[2]), .bit_en(bit_en_a[2]),
    .busy(busy_a[2]), .word_done(word_done_a[2]));

  // An accepted word becomes 8 bits, each repeated CPB clocks, appended after whatever is still pending.
  function automatic void append(input logic [7:0] w);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = (MSB_T[sel] != 0) ? w[7-i] : w[i];
      for (int c = 0; c < CPB_T[sel]; c++)
        exp_q.push_back({b, 1'(c == 0), 1'(i == 7 && c == CPB_T[sel] - 1)});
    end
  endfunction

  // Samples the current clock (obs/expv = {sout, bit_en, word_done, busy, din_ready}), drives the
  // inputs for the coming edge, and advances one clock. More than one word of pending bits
  // means a word is waiting in the buffer, so din_ready must be low.
  task automatic cycle(input logic v, input logic [7:0] d,
                       output logic [4:0] obs, output logic [4:0] expv, output logic acc);
    int n;
    n    = exp_q.size();
    obs  = {sout_a[sel], bit_en_a[sel], word_done_a[sel], busy_a[sel], din_ready_a[sel]};
    expv = {(n > 0) ? exp_q[0] : 3'b000, 1'(n > 0), 1'(n <= 8 * CPB_T[sel])};
    if (n > 0) void'(exp_q.pop_front());
    din_a[sel]       = d;
    din_valid_a[sel] = v;
    acc = v && expv[0];
    @(posedge clk);
    #1;
    if (acc) append(d);
  endtask

  task automatic test_reset();
    logic [4:0] obs, expv;
    logic       acc;
    #12;
    for (int i = 0; i < 3; i++) begin
      obs = {sout_a[i], bit_en_a[i], word_done_a[i], busy_a[i], din_ready_a[i]};
      n_checks++;
      if (obs !== 5'b00001) begin
        n_fails++;
        $display("FAIL reset_state dut%0d: got %b expected 00001", i, obs);
      end
    end
    sel = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    din_a[0] = 8'h81;
    din_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    din_valid_a[0] = 1'b0;
    append(8'h81);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 8'h00, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL first_after_reset c%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_single();
    logic [4:0] obs, expv;
    logic       acc;
    logic [7:0] bits;
    sel  = 0;
    bits = '0;
    for (int k = 0; k <= 11; k++) begin
      cycle(k == 0, 8'hF0, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL single_f0 c%0d: got %b expected %b", k, obs, expv);
      end
      if (k >= 1 && k <= 8) bits = {bits[6:0], obs[4]};
    end
    n_checks++;
    if (bits !== 8'hF0) begin
      n_fails++;
      $display("FAIL single_f0_stream: got %h expected f0", bits);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  obs, expv;
    logic        acc;
    logic [7:0]  words [2];
    logic [15:0] stream;
    int          w, nd;
    sel = 0;
    words[0] = 8'hFF;
    words[1] = 8'h0F;
    w = 0;
    nd = 0;
    stream = '0;
    for (int k = 0; k < 22; k++) begin
      cycle(w < 2, (w < 2) ? words[w] : 8'h00, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL back_to_back c%0d: got %b expected %b", k, obs, expv);
      end
      if (acc) w++;
      if (k >= 1 && k <= 16) stream = {stream[14:0], obs[4]};
      if (obs[2]) nd++;
    end
    n_checks++;
    if (stream !== 16'hFF0F || nd != 2) begin
      n_fails++;
      $display("FAIL back_to_back_stream: got %h/%0d done expected ff0f/2 done", stream, nd);
    end
  endtask

  task automatic test_slow_bits();
    logic [4:0] obs, expv;
    logic       acc;
    logic [7:0] bits;
    int         pulses;
    sel = 1;
    bits = '0;
    pulses = 0;
    for (int k = 0; k <= 28; k++) begin
      cycle(k == 0, 8'hA5, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL slow_a5 c%0d: got %b expected %b", k, obs, expv);
      end
      if (obs[3]) begin
        pulses++;
        bits = {bits[6:0], obs[4]};
      end
    end
    n_checks++;
    if (pulses != 8 || bits !== 8'hA5) begin
      n_fails++;
      $display("FAIL slow_a5_pulses: got %0d pulses bits %h expected 8 pulses bits a5", pulses, bits);
    end
  endtask

  task automatic test_lsb_first();
    logic [4:0] obs, expv;
    logic       acc;
    logic [7:0] bits;
    sel = 2;
    bits = '0;
    for (int k = 0; k <= 11; k++) begin
      cycle(k == 0, 8'h01, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL lsb_01 c%0d: got %b expected %b", k, obs, expv);
      end
      if (k >= 1 && k <= 8) bits = {bits[6:0], obs[4]};
    end
    n_checks++;
    if (bits !== 8'h80) begin
      n_fails++;
      $display("FAIL lsb_01_stream: got %b expected 10000000", bits);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] obs, expv;
    logic       acc;
    sel = 0;
    for (int k = 0; k <= 3; k++) begin
      cycle(k <= 1, (k == 0) ? 8'hFF : 8'hAA, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL reset_mid_pre c%0d: got %b expected %b", k, obs, expv);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {sout_a[0], bit_en_a[0], word_done_a[0], busy_a[0], din_ready_a[0]};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fails++;
      $display("FAIL reset_mid_async: got %b expected 00001", obs);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 8'h00, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL reset_mid_after c%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_last_edge();
    logic [4:0]  obs, expv;
    logic        acc;
    logic [15:0] stream;
    int          ready_low;
    sel = 0;
    stream = '0;
    ready_low = 0;
    for (int k = 0; k <= 20; k++) begin
      cycle(k == 0 || k == 8, (k == 0) ? 8'h3C : 8'hC3, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL last_edge c%0d: got %b expected %b", k, obs, expv);
      end
      if (k >= 1 && k <= 16) stream = {stream[14:0], obs[4]};
      if (!obs[0]) ready_low++;
    end
    n_checks++;
    if (stream !== 16'h3CC3 || ready_low != 0) begin
      n_fails++;
      $display("FAIL last_edge_stream: got %h ready_low=%0d expected 3cc3 ready_low=0", stream, ready_low);
    end
  endtask

  task automatic test_random();
    logic [4:0] obs, expv;
    logic       acc, v;
    logic [7:0] d;
    int         k;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      v = 1'b0;
      d = 8'h00;
      for (int c = 0; c < 200; c++) begin
        // The source keeps a refused word stable until it is taken.
        if (!v || acc) begin
          v = ($urandom_range(0, 3) != 0);
          d = 8'($urandom);
        end
        cycle(v, d, obs, expv, acc);
        n_checks++;
        if (obs !== expv) begin
          n_fails++;
          $display("FAIL random dut%0d c%0d: got %b expected %b", s, c, obs, expv);
        end
      end
      k = 0;
      while (exp_q.size() > 0 && k < 120) begin
        cycle(1'b0, 8'h00, obs, expv, acc);
        n_checks++;
        if (obs !== expv) begin
          n_fails++;
          $display("FAIL random_drain dut%0d c%0d: got %b expected %b", s, k, obs, expv);
        end
        k++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fails++;
        $display("FAIL random_drain_timeout dut%0d: %0d clocks still pending expected 0", s, exp_q.size());
      end
      exp_q.delete();
      cycle(1'b0, 8'h00, obs, expv, acc);
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL random_idle dut%0d: got %b expected %b", s, obs, expv);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    sel      = 0;
    for (int i = 0; i < 3; i++) begin
      din_a[i]       = 8'h00;
      din_valid_a[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_bits();
    test_lsb_first();
    test_reset_mid_word();
    test_last_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (2..32).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, clocks each bit is held on sout (1..256).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = shift LSB first.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port din_valid  input  1  din holds a word.
REQ-008 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port sout  output  1  registered serial bit stream, feeds the downstream run detector's ain.
REQ-010 SHALL have port bit_en  output  1  one-cycle pulse in the first clock of each bit period.
REQ-011 SHALL have port busy  output  1  high while a word is being shifted.
REQ-012 SHALL have port word_done  output  1  one-cycle pulse in the last clock of a word's last bit period.

Function
REQ-013 SHALL transfer a word on any rising edge where din_valid=1 and din_ready=1; no transfer otherwise.
REQ-014 SHALL contain a one-word holding buffer; din_ready SHALL equal NOT(buffer full), combinationally.
REQ-015 SHALL implement two states: IDLE (sout=0, busy=0) and SHIFT (busy=1).
REQ-016 IDLE: a transfer SHALL load the shift register directly (buffer stays empty) and enter SHIFT on the same edge.
REQ-017 SHALL present the first bit on sout in the clock immediately after the transfer edge (latency 1 cycle), with bit_en=1 that cycle.
REQ-018 SHALL hold each bit on sout for exactly CLKS_PER_BIT clocks, using a divider counter of ceil(log2(CLKS_PER_BIT)) bits, minimum 1.
REQ-019 SHALL output bits in order MSB..LSB when MSB_FIRST=1, LSB..MSB when MSB_FIRST=0.
REQ-020 SHIFT: a transfer SHALL write the holding buffer.
REQ-021 At the end of the last bit period: if the buffer is full, SHALL load it into the shift register, clear the buffer, stay in SHIFT; the next word's first bit SHALL follow with no gap.
REQ-022 At the end of the last bit period with the buffer empty but a transfer on that same edge, SHALL load din directly into the shift register with no gap; the buffer stays empty.
REQ-023 At the end of the last bit period with no word available, SHALL enter IDLE; sout SHALL be 0 from the next clock.
REQ-024 word_done SHALL pulse once per word, including back-to-back words.
REQ-025 A din_valid held high with din_ready=0 SHALL cause no transfer and no change to din's pending word.
REQ-026 A word accepted into the buffer SHALL never be dropped or duplicated except by reset.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, sout=0, bit_en=0, busy=0, word_done=0, buffer empty, counters 0.
REQ-028 din_ready SHALL read 1 after reset is released (buffer empty).
REQ-029 Reset asserted mid-word SHALL discard the shift register and buffer contents; no partial word resumes after release.
REQ-030 First transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-031 WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1: send 8'hF0 -> sout=1,1,1,1,0,0,0,0 in cycles 1..8 after transfer, then 0; word_done in cycle 8; busy high cycles 1..8.
REQ-032 Back-to-back 8'hFF then 8'h0F, din_valid held -> 16 contiguous bits 11111111 00001111 with no gap; din_ready=0 while buffer full; two word_done pulses, cycles 8 and 16.
REQ-033 CLKS_PER_BIT=3: send 8'hA5 -> each bit of 10100101 held 3 clocks (24 clocks total); bit_en pulses every 3rd clock, 8 pulses.
REQ-034 MSB_FIRST=0: send 8'h01 -> sout=1 in cycle 1, then 0 for cycles 2..8.
REQ-035 Reset pulse in cycle 4 of 8'hFF with a buffered 8'hAA -> sout=0, busy=0, din_ready=1 immediately; no bits of 8'hAA appear after release.
REQ-036 Second word presented exactly on the last-bit edge with buffer empty -> no gap between words, din_ready stays 1.
